pcg_multi: RTL and testbench

//  N_CH-channel PCG generator with a valid/ready output and a synchronous seeding FSM.

---
 rtl/pcg_pkg.sv | 52 +++++
 rtl/pcg_lane.sv | 126 ++++++++++++
 rtl/pcg_multi.sv | 135 +++++++++++++
 tb/tb_pcg_multi.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcg_pkg.sv
// Package: pcg_pkg
// Shared constants, FSM encoding and output permutations for the multi-channel
// PCG generator (pcg_multi / pcg_lane).
//   STATE_W      : LCG state width (64)
//   PCG_MUL      : LCG multiplier, all arithmetic is mod 2^64
//   fsm_e        : seeding / run controller states
//   perm_xsh_rr  : XSH-RR output permutation (32-bit or 16-bit output)
//   perm_xsh_rs  : XSH-RS output permutation (32-bit or 16-bit output)
package pcg_pkg;

  localparam int STATE_W = 64;
  localparam logic [STATE_W-1:0] PCG_MUL = 64'd6364136223846793005;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED0 = 2'd1,
    SEED1 = 2'd2,
    RUN   = 2'd3
  } fsm_e;

  // Xorshift-high then rotate right by the top state bits.
  // Result is right-aligned; the 16-bit variant leaves the upper half zero.
  function automatic logic [31:0] perm_xsh_rr(input logic [STATE_W-1:0] s,
                                              input logic w16);
    logic [31:0] x;
    logic [15:0] x16;
    logic [4:0]  r;
    if (w16) begin
      x16 = 16'(((s >> 10) ^ s) >> 45);
      r   = {1'b0, s[63:60]};
      // A left shift by 16 on a 16-bit value yields 0, so r = 0 is a clean no-op.
      return {16'h0000, (x16 >> r) | (x16 << (5'd16 - r))};
    end
    x = 32'(((s >> 18) ^ s) >> 27);
    r = s[63:59];
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction

  // Xorshift-high then a data-dependent right shift selected by the top 3 bits.
  // The 16-bit variant shifts by 41..48 so the window stays inside the state.
  function automatic logic [31:0] perm_xsh_rs(input logic [STATE_W-1:0] s,
                                              input logic w16);
    logic [5:0] sh;
    if (w16) begin
      sh = 6'd41 + {3'b000, s[63:61]};
      return {16'h0000, 16'(((s >> 11) ^ s) >> sh)};
    end
    sh = 6'd22 + {3'b000, s[63:61]};
    return 32'(((s >> 22) ^ s) >> sh);
  endfunction

endpackage

// File: rtl/pcg_lane.sv
// Module: pcg_lane
// One PCG channel: latched seed and stream increment, 64-bit LCG state and the
// registered permuted output. Sequencing comes from pcg_multi.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load            : latch seed_in and inc = {seq_in,1}
//   seed_in, seq_in : per-channel initstate / stream id
//   step_seed0/1    : perform the two seeding steps
//   step_run        : emit perm(state) and advance the LCG
//   mode_rr         : 1 = XSH-RR, 0 = XSH-RS
//   out_data        : registered permuted output
// Optional (macro PCG_HEALTH_EN):
//   accept, clr     : sample accepted downstream / clear repeat tracking
//   rep_hit         : 4th consecutive equal accepted sample
module pcg_lane
  import pcg_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [STATE_W-1:0] seed_in,
  input  logic [STATE_W-2:0] seq_in,
  input  logic               step_seed0,
  input  logic               step_seed1,
  input  logic               step_run,
  input  logic               mode_rr,
`ifdef PCG_HEALTH_EN
  input  logic               accept,
  input  logic               clr,
  output logic               rep_hit,
`endif
  output logic [OUT_W-1:0]   out_data
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] inc_q, inc_d;
  logic [STATE_W-1:0] seed_q, seed_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [31:0]        perm;

  always_comb begin
    perm = mode_rr ? perm_xsh_rr(state_q, OUT_W == 16)
                   : perm_xsh_rs(state_q, OUT_W == 16);
  end

  always_comb begin
    state_d = state_q;
    inc_d   = inc_q;
    seed_d  = seed_q;
    out_d   = out_q;
    if (load) begin
      seed_d = seed_in;
      inc_d  = {seq_in, 1'b1};
    end
    if (step_seed0) begin
      // 0*MUL + inc
      state_d = inc_q;
    end else if (step_seed1) begin
      state_d = (state_q + seed_q) * PCG_MUL + inc_q;
    end else if (step_run) begin
      // Output comes from the pre-advance state.
      out_d   = perm[OUT_W-1:0];
      state_d = state_q * PCG_MUL + inc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      inc_q   <= 64'd1;
      seed_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      seed_q  <= seed_d;
      out_q   <= out_d;
    end
  end

  assign out_data = out_q;

`ifdef PCG_HEALTH_EN
  logic [OUT_W-1:0] last_q, last_d;
  logic [1:0]       rep_q, rep_d;
  logic             have_q, have_d;
  logic             same;

  always_comb begin
    same    = have_q && (out_q == last_q);
    last_d  = last_q;
    rep_d   = rep_q;
    have_d  = have_q;
    rep_hit = 1'b0;
    if (clr) begin
      rep_d  = 2'd0;
      have_d = 1'b0;
    end else if (accept) begin
      have_d = 1'b1;
      last_d = out_q;
      // rep counts repeats after the first sample; the third repeat is the 4th equal value.
      if (same) begin
        rep_hit = (rep_q >= 2'd2);
        if (rep_q != 2'd3) rep_d = rep_q + 2'd1;
      end else begin
        rep_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      rep_q  <= 2'd0;
      have_q <= 1'b0;
    end else begin
      last_q <= last_d;
      rep_q  <= rep_d;
      have_q <= have_d;
    end
  end
`endif

endmodule

// File: rtl/pcg_multi.sv
// Module: pcg_multi
// N_CH-channel PCG generator. All lanes step in lockstep behind one
// valid/ready output; a small FSM runs the two-step srandom seeding.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   seed_load  : pulse to (re)seed every channel, aborts any run in progress
//   seed       : N_CH*64 initstate, ch i at [64i+:64]
//   seq        : N_CH*63 stream id, ch i at [63i+:63]
//   mode_rr    : permutation select, sampled with seed_load
//   busy       : high while not in RUN
//   out_valid, out_ready : output handshake
//   out_data   : N_CH*OUT_W, ch i at [OUT_W*i+:OUT_W]
// Optional macro PCG_HEALTH_EN adds health_fail: sticky flag, set when any
// channel delivers the same value on 4 consecutive accepted samples, cleared
// by rst or seed_load.
module pcg_multi
  import pcg_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int OUT_W   = 32,
  parameter int PERM_RR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed_load,
  input  logic [N_CH*64-1:0]    seed,
  input  logic [N_CH*63-1:0]    seq,
  input  logic                  mode_rr,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_CH*OUT_W-1:0] out_data
`ifdef PCG_HEALTH_EN
  ,
  output logic                  health_fail
`endif
);

  fsm_e fsm_q, fsm_d;
  logic valid_q, valid_d;
  logic mode_q, mode_d;
  logic load, step_seed0, step_seed1, step_run;

  always_comb begin
    fsm_d      = fsm_q;
    valid_d    = valid_q;
    mode_d     = mode_q;
    load       = 1'b0;
    step_seed0 = 1'b0;
    step_seed1 = 1'b0;
    step_run   = 1'b0;
    case (fsm_q)
      IDLE:  fsm_d = IDLE;
      SEED0: begin
        step_seed0 = 1'b1;
        fsm_d      = SEED1;
      end
      SEED1: begin
        step_seed1 = 1'b1;
        fsm_d      = RUN;
      end
      RUN: begin
        if (!valid_q || out_ready) begin
          step_run = 1'b1;
          valid_d  = 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
    // A seed request from any state restarts seeding and drops any held sample.
    if (seed_load) begin
      fsm_d      = SEED0;
      load       = 1'b1;
      mode_d     = mode_rr;
      valid_d    = 1'b0;
      step_seed0 = 1'b0;
      step_seed1 = 1'b0;
      step_run   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      valid_q <= 1'b0;
      mode_q  <= (PERM_RR != 0);
    end else begin
      fsm_q   <= fsm_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
    end
  end

  assign busy      = (fsm_q != RUN);
  assign out_valid = valid_q;

`ifdef PCG_HEALTH_EN
  logic [N_CH-1:0] hit;
  logic            health_q, health_d;

  always_comb begin
    health_d = health_q;
    if (seed_load)  health_d = 1'b0;
    else if (|hit)  health_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) health_q <= 1'b0;
    else     health_q <= health_d;
  end

  assign health_fail = health_q;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    pcg_lane #(.OUT_W(OUT_W)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .seed_in    (seed[64*i +: 64]),
      .seq_in     (seq[63*i +: 63]),
      .step_seed0 (step_seed0),
      .step_seed1 (step_seed1),
      .step_run   (step_run),
      .mode_rr    (mode_q),
`ifdef PCG_HEALTH_EN
      .accept     (valid_q && out_ready),
      .clr        (seed_load),
      .rep_hit    (hit[i]),
`endif
      .out_data   (out_data[OUT_W*i +: OUT_W])
    );
  end

endmodule

// File: tb/tb_pcg_multi.sv
// Testbench for pcg_multi (N_CH=2, OUT_W=32). A reference PCG model written
// from the pcg32 C algorithm predicts every accepted sample; directed literals
// pin both the model and the DUT. With PCG_HEALTH_EN defined the health flag
// is also exercised.
module tb_pcg_multi;

  localparam int N_CH = 2;
  localparam longint unsigned MUL = 64'd6364136223846793005;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 seed_load = 1'b0;
  logic [N_CH*64-1:0]   seed = '0;
  logic [N_CH*63-1:0]   seq = '0;
  logic                 mode_rr = 1'b1;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [N_CH*32-1:0]   out_data;
`ifdef PCG_HEALTH_EN
  logic                 health_fail;
`endif

  pcg_multi #(.N_CH(N_CH), .OUT_W(32), .PERM_RR(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .seq       (seq),
    .mode_rr   (mode_rr),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PCG_HEALTH_EN
    ,
    .health_fail (health_fail)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_rr [4] = '{32'ha15c02b7, 32'h7b47f409, 32'hba1d3330, 32'h83d2f293};

  // ---------------- reference model (pcg32 C algorithm) ----------------
  function automatic longint unsigned m_init(longint unsigned initstate,
                                             longint unsigned initseq);
    longint unsigned s, inc;
    inc = (initseq << 1) | 64'd1;
    s   = 0;
    s   = s * MUL + inc;
    s   = s + initstate;
    s   = s * MUL + inc;
    return s;
  endfunction

  function automatic longint unsigned m_next(longint unsigned s, longint unsigned inc);
    return s * MUL + inc;
  endfunction

  function automatic logic [31:0] m_out(longint unsigned s, bit rr);
    logic [31:0] xs;
    int unsigned rot, sh;
    if (rr) begin
      xs  = 32'(((s >> 18) ^ s) >> 27);
      rot = 32'(s >> 59);
      return (xs >> rot) | (xs << ((32 - rot) & 31));
    end
    sh = 22 + 32'(s >> 61);
    return 32'(((s >> 22) ^ s) >> sh);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- cycle-by-cycle compare process ----------------
  longint unsigned mst [N_CH];
  longint unsigned minc [N_CH];
  bit              mrr;
  bit              armed = 0;
  bit              chk_en = 1;
  bit              hold_v = 0;
  logic [N_CH*32-1:0] held;
  int              n_acc = 0;
  logic [31:0]     first_acc = '0;

  always @(negedge clk) begin
    if (rst) begin
      armed  = 0;
      hold_v = 0;
    end else if (seed_load) begin
      for (int c = 0; c < N_CH; c++) begin
        minc[c] = ({1'b0, seq[63*c +: 63]} << 1) | 64'd1;
        mst[c]  = m_init(seed[64*c +: 64], {1'b0, seq[63*c +: 63]});
      end
      mrr    = mode_rr;
      armed  = 1;
      hold_v = 0;
      n_acc  = 0;
    end else if (chk_en) begin
      if (hold_v) begin
        vectors++;
        if (!out_valid || out_data !== held) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%h, expected valid=1 data=%h",
                   out_valid, out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        for (int c = 0; c < N_CH; c++) begin
          logic [31:0] want;
          want = armed ? m_out(mst[c], mrr) : 32'h0;
          vectors++;
          if (!armed || out_data[32*c +: 32] !== want) begin
            errors++;
            $display("FAIL stream ch%0d sample %0d: got %h, expected %h (armed=%0b)",
                     c, n_acc, out_data[32*c +: 32], want, armed);
          end
          mst[c] = m_next(mst[c], minc[c]);
        end
        if (n_acc == 0) first_acc = out_data[31:0];
        n_acc++;
      end
      hold_v = out_valid && !out_ready;
      held   = out_data;
    end else begin
      hold_v = 0;
    end
  end

  task automatic do_seed(input logic [63:0] s0, input logic [62:0] q0,
                         input logic [63:0] s1, input logic [62:0] q1,
                         input logic rr);
    seed      = {s1, s0};
    seq       = {q1, q0};
    mode_rr   = rr;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    longint unsigned s;

    // Pin the model itself against the published pcg32 (42,54) sequence.
    s = m_init(64'd42, 64'd54);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("model_pin_%0d", k), {32'h0, m_out(s, 1'b1)}, {32'h0, exp_rr[k]});
      s = m_next(s, 64'd109);
    end

    // 1. reset
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy",  {63'h0, busy},      64'd1);
    chk("rst_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_data",  {32'h0, out_data[31:0]} | {out_data[63:32], 32'h0}, 64'd0);
    rst = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("idle_busy",  {63'h0, busy},      64'd1);
    chk("idle_valid", {63'h0, out_valid}, 64'd0);

    // 2 + 4. seeding, XSH-RR, two independent streams
    step();
    do_seed(64'd42, 63'd54, 64'd42, 63'd55, 1'b1);
    @(negedge clk);
    chk("seed0_busy", {63'h0, busy}, 64'd1);
    step();
    step();
    @(negedge clk);
    chk("run_busy",        {63'h0, busy},      64'd0);
    chk("run_first_valid", {63'h0, out_valid}, 64'd0);
    step();
    @(negedge clk);
    chk("first_valid", {63'h0, out_valid}, 64'd1);
    chk("rr_0", {32'h0, out_data[31:0]}, {32'h0, exp_rr[0]});
    vectors++;
    if (out_data[63:32] == out_data[31:0]) begin
      errors++;
      $display("FAIL lanes_differ: ch1 %h equals ch0 %h", out_data[63:32], out_data[31:0]);
    end
    for (int k = 1; k < 4; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("rr_%0d", k), {32'h0, out_data[31:0]}, {32'h0, exp_rr[k]});
    end

    // 3. backpressure with random ready
    step();
    do_seed(64'd42, 63'd54, 64'd42, 63'd55, 1'b1);
    for (int k = 0; k < 60; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_progress", {63'h0, n_acc >= 4}, 64'd1);
    chk("bp_first", {32'h0, first_acc}, {32'h0, exp_rr[0]});

    // XSH-RS mode on different seeds (model-checked stream)
    step();
    do_seed(64'hdeadbeef_cafef00d, 63'd7, 64'd1, 63'h7fff_ffff_ffff_ffff, 1'b0);
    repeat (14) step();
    for (int k = 0; k < 20; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b1;
    step();

    // 5a. seed_load mid-run after the 2nd sample
    do_seed(64'd42, 63'd54, 64'd42, 63'd55, 1'b1);
    step();
    step();
    step();
    step();
    @(negedge clk);
    chk("mid_second", {32'h0, out_data[31:0]}, {32'h0, exp_rr[1]});
    step();
    do_seed(64'd42, 63'd54, 64'd42, 63'd55, 1'b1);
    @(negedge clk);
    chk("abort_valid", {63'h0, out_valid}, 64'd0);
    step();
    step();
    step();
    @(negedge clk);
    chk("restart_valid", {63'h0, out_valid}, 64'd1);
    chk("restart_data", {32'h0, out_data[31:0]}, {32'h0, exp_rr[0]});

    // 5b. reset mid-run
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("midrst_busy",  {63'h0, busy},      64'd1);
    chk("midrst_valid", {63'h0, out_valid}, 64'd0);
    chk("midrst_data",  {32'h0, out_data[31:0]} | {out_data[63:32], 32'h0}, 64'd0);

    // seed_load while rst is high is ignored
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    rst = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("rstload_busy",  {63'h0, busy},      64'd1);
    chk("rstload_valid", {63'h0, out_valid}, 64'd0);

`ifdef PCG_HEALTH_EN
    // 6. health flag: pin lane 0 state so its output repeats
    step();
    do_seed(64'd42, 63'd54, 64'd42, 63'd55, 1'b1);
    repeat (4) step();
    @(negedge clk);
    chk("health_clear0", {63'h0, health_fail}, 64'd0);
    chk_en = 0;
    force dut.g_lane[0].u_lane.state_q = 64'h0123_4567_89ab_cdef;
    repeat (8) step();
    @(negedge clk);
    chk("health_set", {63'h0, health_fail}, 64'd1);
    release dut.g_lane[0].u_lane.state_q;
    step();
    do_seed(64'd42, 63'd54, 64'd42, 63'd55, 1'b1);
    @(negedge clk);
    chk("health_cleared", {63'h0, health_fail}, 64'd0);
    chk_en = 1;
    repeat (6) step();
`else
    $display("note: health flag not built, health test skipped");
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
